muldiv_sequencer: RTL and testbench

Sequences the shared multiply and divide units for the multicycle CPU.
- Accepts one MULT/DIV request from the main control unit.
- Pulses the selected unit's init line and waits for its stop line.
- Steers and loads the High/Low registers, then reports done.
- Detects divide-by-zero before starting the divider. Optionally guards against a hung unit with a watchdog.

---
 rtl/muldiv_pkg.sv | 21 ++
 rtl/muldiv_watchdog.sv | 32 +++
 rtl/muldiv_sequencer.sv | 119 +++++++++++
 tb/tb_muldiv_sequencer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: state encoding and operation/select constants shared by the
// multiply/divide sequencer and its watchdog.
package muldiv_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5,
        TOUT  = 3'd6
    } muldiv_state_t;

    localparam logic OP_MULT  = 1'b0;
    localparam logic OP_DIV   = 1'b1;

    localparam logic SEL_MULT = 1'b0;
    localparam logic SEL_DIV  = 1'b1;

endpackage

// File: rtl/muldiv_watchdog.sv
// muldiv_watchdog: counts cycles spent waiting for a multiply/divide unit and
// flags when the wait has lasted MAX_CYCLES cycles. Only built when the
// sequencer is compiled with MULDIV_TIMEOUT_EN.
module muldiv_watchdog #(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The last WAIT cycle that is still allowed carries count MAX_CYCLES-1;
    // the edge ending it is where the count reaches MAX_CYCLES.
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Restart the count when the sequencer is about to enter WAIT, then count each WAIT cycle.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

    assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/muldiv_sequencer.sv
// muldiv_sequencer: runs one MULT/DIV request on the shared multiplier or
// divider, loads the High/Low registers and reports completion. A zero divisor
// raises div_zero without touching the divider. Defining MULDIV_TIMEOUT_EN
// adds a watchdog that abandons a unit that never raises its stop line.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int MAX_CYCLES = 64,
    parameter int CNT_W      = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        op,
    input  logic [31:0] divisor,
    output logic        mult_init,
    input  logic        mult_stop,
    output logic        div_init,
    input  logic        div_stop,
    output logic        hilo_sel,
    output logic        hi_load,
    output logic        lo_load,
    output logic        busy,
    output logic        done,
    output logic        div_zero,
    output logic        timeout
);

    muldiv_state_t state;
    logic          sel_stop;
    logic          wd_expired;

    // hilo_sel remembers which unit was started, so it also picks the stop line to watch.
    assign sel_stop = (hilo_sel == SEL_DIV) ? div_stop : mult_stop;

`ifdef MULDIV_TIMEOUT_EN
    muldiv_watchdog #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (CNT_W)
    ) u_watchdog (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == START),
        .enable  (state == WAIT),
        .expired (wd_expired)
    );
`else
    // Without the watchdog the sizing parameters have no effect.
    logic unused_cfg;
    assign unused_cfg = (CNT_W > 0) && (MAX_CYCLES > 0);
    assign wd_expired = 1'b0;
`endif

    // Sequencer FSM; every output is registered alongside the state it belongs to.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            hilo_sel  <= SEL_MULT;
            mult_init <= 1'b0;
            div_init  <= 1'b0;
            hi_load   <= 1'b0;
            lo_load   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            mult_init <= 1'b0;
            div_init  <= 1'b0;
            hi_load   <= 1'b0;
            lo_load   <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            timeout   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        busy <= 1'b1;
                        if ((op == OP_DIV) && (divisor == 32'd0)) begin
                            state    <= EXC;
                            div_zero <= 1'b1;
                        end else begin
                            state     <= START;
                            hilo_sel  <= (op == OP_DIV) ? SEL_DIV : SEL_MULT;
                            mult_init <= (op == OP_MULT);
                            div_init  <= (op == OP_DIV);
                        end
                    end
                end
                START: begin
                    state <= WAIT;
                end
                WAIT: begin
                    if (sel_stop) begin
                        state   <= WRITE;
                        hi_load <= 1'b1;
                        lo_load <= 1'b1;
                    end else if (wd_expired) begin
                        state   <= TOUT;
                        timeout <= 1'b1;
                    end
                end
                WRITE: begin
                    state <= DONE;
                    done  <= 1'b1;
                end
                DONE, EXC, TOUT: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb_muldiv_sequencer: directed and randomized transactions against a
// timeline model of the sequencer. Honours MULDIV_TIMEOUT_EN like the design.
`timescale 1ns/1ps
module tb_muldiv_sequencer;

    localparam int MAX_CYCLES = 64;
    localparam int NEVER      = 1000000;
`ifdef MULDIV_TIMEOUT_EN
    localparam bit TOUT_BUILD = 1'b1;
`else
    localparam bit TOUT_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req = 1'b0;
    logic        op = 1'b0;
    logic [31:0] divisor = 32'd0;
    logic        mult_stop = 1'b0;
    logic        div_stop = 1'b0;
    logic        mult_init, div_init, hilo_sel, hi_load, lo_load;
    logic        busy, done, div_zero, timeout;

    int   total = 0;
    int   bad = 0;
    logic prevSel = 1'b0;

    always #5 clk = ~clk;

    muldiv_sequencer #(
        .MAX_CYCLES (MAX_CYCLES),
        .CNT_W      (7)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .op        (op),
        .divisor   (divisor),
        .mult_init (mult_init),
        .mult_stop (mult_stop),
        .div_init  (div_init),
        .div_stop  (div_stop),
        .hilo_sel  (hilo_sel),
        .hi_load   (hi_load),
        .lo_load   (lo_load),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero),
        .timeout   (timeout)
    );

    // Output order: mult_init div_init hilo_sel hi_load lo_load busy done div_zero timeout
    function automatic logic [8:0] packOut();
        return {mult_init, div_init, hilo_sel, hi_load, lo_load, busy, done, div_zero, timeout};
    endfunction

    task automatic checkOutput(input string tag, input logic [8:0] got, input logic [8:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic applyReset();
        reset = 1'b1;
        req = 1'b0;
        mult_stop = 1'b0;
        div_stop = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", packOut(), 9'b0);
        reset = 1'b0;
        prevSel = 1'b0;
    endtask

    // One request issued at edge 0. stopEdge is the edge at which the selected
    // unit's stop is sampled (-1 = never), strayEdge pulses the other unit's
    // stop, extraEdge raises a second req while busy. Expected outputs per cycle
    // come from the latency rules: init in cycle 1, loads at stop+1, done at stop+2.
    task automatic applyStimulus(input string name, input logic opIn, input logic [31:0] divIn,
                                 input int stopEdge, input int strayEdge, input int extraEdge,
                                 input bit holdStop, input int tail);
        bit         isZero, normal, tout;
        int         lastBusy, horizon;
        logic       selExp;
        logic [8:0] want;
        isZero = (opIn == 1'b1) && (divIn == 32'd0);
        normal = !isZero && (stopEdge >= 2) && (!TOUT_BUILD || stopEdge <= MAX_CYCLES + 1);
        tout   = !isZero && !normal && TOUT_BUILD;
        if (isZero)      lastBusy = 1;
        else if (normal) lastBusy = stopEdge + 2;
        else if (tout)   lastBusy = MAX_CYCLES + 2;
        else             lastBusy = NEVER;
        horizon = (lastBusy == NEVER) ? 100 : lastBusy + 1 + tail;
        selExp  = isZero ? prevSel : opIn;
        for (int t = 0; t < horizon; t++) begin
            bit stopNow;
            int c;
            stopNow   = (stopEdge >= 0) && ((t == stopEdge) || (holdStop && t > stopEdge));
            req       = (t == 0) || (t == extraEdge);
            op        = (t == 0) ? opIn : ~opIn;
            divisor   = (t == 0) ? divIn : $urandom;
            mult_stop = (opIn == 1'b0) ? stopNow : (t == strayEdge);
            div_stop  = (opIn == 1'b1) ? stopNow : (t == strayEdge);
            @(posedge clk);
            #1;
            c = t + 1;
            want = {(!isZero && !opIn && c == 1),
                    (!isZero && opIn && c == 1),
                    selExp,
                    (normal && c == stopEdge + 1),
                    (normal && c == stopEdge + 1),
                    (c <= lastBusy),
                    (normal && c == stopEdge + 2),
                    (isZero && c == 1),
                    (tout && c == MAX_CYCLES + 2)};
            checkOutput($sformatf("%s c%0d", name, c), packOut(), want);
        end
        req = 1'b0;
        mult_stop = 1'b0;
        div_stop = 1'b0;
        prevSel = selExp;
    endtask

    initial begin
        applyReset();

        // Directed cases
        applyStimulus("mult", 1'b0, 32'd5, 34, -1, -1, 1'b0, 2);
        applyStimulus("div_stray", 1'b1, 32'd7, 20, 10, -1, 1'b0, 2);
        applyStimulus("divzero_keep1", 1'b1, 32'h0, -1, -1, -1, 1'b0, 2);
        applyStimulus("mult2", 1'b0, 32'd3, 6, 4, -1, 1'b0, 1);
        applyStimulus("divzero_keep0", 1'b1, 32'h0, -1, -1, 1, 1'b0, 2);
        applyStimulus("busy_req", 1'b0, 32'd3, 15, -1, 8, 1'b0, 2);
        applyStimulus("req_at_done", 1'b1, 32'd9, 12, -1, 14, 1'b0, 2);
        applyStimulus("held_stop", 1'b1, 32'd2, 5, -1, -1, 1'b1, 3);
        applyStimulus("fast_stop", 1'b0, 32'd1, 2, -1, -1, 1'b0, 1);

        // Reset while waiting on the divider: nothing completes afterwards
        req = 1'b1;
        op = 1'b1;
        divisor = 32'd11;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        checkOutput("rst_pre_busy", packOut(), 9'b0_0_1_0_0_1_0_0_0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("rst_mid", packOut(), 9'b0);
        reset = 1'b0;
        prevSel = 1'b0;
        div_stop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            checkOutput($sformatf("rst_after%0d", i), packOut(), 9'b0);
        end
        div_stop = 1'b0;

        // Watchdog behaviour depends on the build
        if (TOUT_BUILD) begin
            applyStimulus("wd_tout", 1'b0, 32'd5, -1, -1, -1, 1'b0, 2);
            applyStimulus("wd_edge", 1'b1, 32'd9, MAX_CYCLES + 1, -1, -1, 1'b0, 2);
        end else begin
            applyStimulus("wd_none", 1'b0, 32'd5, -1, -1, -1, 1'b0, 0);
            applyReset();
        end

        // Randomized transactions
        for (int n = 0; n < 25; n++) begin
            logic        rOp;
            logic [31:0] rDiv;
            int          rStop, rStray, rExtra;
            bit          rHold;
            rOp    = 1'($urandom_range(0, 1));
            rDiv   = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            rStop  = $urandom_range(2, 40);
            rStray = (rStop > 2 && $urandom_range(0, 1) == 1) ? $urandom_range(2, rStop - 1) : -1;
            rExtra = ($urandom_range(0, 2) == 0) ? $urandom_range(1, rStop + 2) : -1;
            if (rOp == 1'b1 && rDiv == 32'd0 && rExtra > 1) rExtra = 1;
            rHold  = ($urandom_range(0, 3) == 0);
            applyStimulus($sformatf("rnd%0d", n), rOp, rDiv, rStop, rStray, rExtra, rHold,
                          $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
